// File: rtl/dpus_pkg.sv
// rtl/dpus_pkg.sv - shared types and DPUSControl encodings for the DPUS sequencer
package dpus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_e;

  localparam int DPUS_FPU_BIT = 3;

  // Flag vector layout {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // DPUSControl codes: bit3 clear selects the ALU, bit3 set selects the FPU
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_ORR   = 4'b0011;
  localparam logic [3:0] OP_EOR   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_UMULL = 4'b0110;
  localparam logic [3:0] OP_SMULL = 4'b0111;
  localparam logic [3:0] OP_FADD  = 4'b1000;
  localparam logic [3:0] OP_FSUB  = 4'b1001;
  localparam logic [3:0] OP_FMUL  = 4'b1010;
  localparam logic [3:0] OP_FDIV  = 4'b1011;

  function automatic logic is_fpu(input logic [3:0] ctrl);
    return ctrl[DPUS_FPU_BIT];
  endfunction

endpackage

// File: rtl/dpus_sequencer.sv
// rtl/dpus_sequencer.sv - issue/wait/writeback controller in front of the DPUS
module dpus_sequencer
  import dpus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FPU_LAT = 3,
  parameter int RA_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_ctrl,
  input  logic             req_long,
  input  logic             req_setflags,
  input  logic [WIDTH-1:0] req_srca,
  input  logic [WIDTH-1:0] req_srcb,
  input  logic [RA_W-1:0]  req_rd,
  input  logic [RA_W-1:0]  req_rd_hi,
  output logic [WIDTH-1:0] dpus_a,
  output logic [WIDTH-1:0] dpus_b,
  output logic [3:0]       dpus_ctrl,
  input  logic [WIDTH-1:0] dpus_result,
  input  logic [WIDTH-1:0] dpus_aux,
  input  logic [3:0]       dpus_flags,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             flags_we,
  output logic [3:0]       flags_out,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, aux_q, wd_q;
  logic [3:0]       ctrl_q, flg_q, cnt_q;
  logic [RA_W-1:0]  rd_q, rd_hi_q, wa_q;
  logic             setflags_q, long_q;
  logic             accept, capture;

  assign accept  = req_valid & req_ready;
  // ALU results are ready on the first EXEC cycle; FPU waits out its latency
  assign capture = (state_q == EXEC) &&
                   (is_fpu(ctrl_q) ? (cnt_q == 4'(FPU_LAT)) : 1'b1);

  assign dpus_a    = a_q;
  assign dpus_b    = b_q;
  assign dpus_ctrl = ctrl_q;
  assign flags_out = flg_q;

  // Next-state and Moore outputs; address/data fall back to the last written values
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = wa_q;
    rf_wd     = wd_q;
    flags_we  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = EXEC;
      end
      EXEC: begin
        if (capture) state_d = WB_LO;
      end
      WB_LO: begin
        rf_we    = 1'b1;
        rf_wa    = rd_q;
        rf_wd    = res_q;
        flags_we = setflags_q;
        done     = ~long_q;
        state_d  = long_q ? WB_HI : IDLE;
      end
      WB_HI: begin
        rf_we   = 1'b1;
        rf_wa   = rd_hi_q;
        rf_wd   = aux_q;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch and EXEC latency counter; FPU ops carry no Auxiliar so long is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rd_hi_q    <= '0;
      setflags_q <= 1'b0;
      long_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      a_q        <= req_srca;
      b_q        <= req_srcb;
      ctrl_q     <= req_ctrl;
      rd_q       <= req_rd;
      rd_hi_q    <= req_rd_hi;
      setflags_q <= req_setflags;
      long_q     <= req_long & ~req_ctrl[DPUS_FPU_BIT];
      cnt_q      <= 4'd1;
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Capture DPUS outputs and remember the last register-file write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      aux_q <= '0;
      flg_q <= '0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      if (capture) begin
        res_q <= dpus_result;
        aux_q <= dpus_aux;
        flg_q <= dpus_flags;
      end
      if (rf_we) begin
        wa_q <= rf_wa;
        wd_q <= rf_wd;
      end
    end
  end

endmodule

// File: tb/tb_dpus_sequencer.sv
// tb/tb_dpus_sequencer.sv - scoreboard bench for dpus_sequencer with a programmable DPUS stub
module tb_dpus_sequencer;
  import dpus_pkg::*;

  localparam int WIDTH   = 32;
  localparam int FPU_LAT = 3;
  localparam int RA_W    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_ctrl = '0;
  logic             req_long = 1'b0;
  logic             req_setflags = 1'b0;
  logic [WIDTH-1:0] req_srca = '0;
  logic [WIDTH-1:0] req_srcb = '0;
  logic [RA_W-1:0]  req_rd = '0;
  logic [RA_W-1:0]  req_rd_hi = '0;
  logic [WIDTH-1:0] dpus_a, dpus_b;
  logic [3:0]       dpus_ctrl;
  logic [WIDTH-1:0] dpus_result = '0;
  logic [WIDTH-1:0] dpus_aux = '0;
  logic [3:0]       dpus_flags = '0;
  logic             rf_we, flags_we, done;
  logic [RA_W-1:0]  rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic [3:0]       flags_out;

  dpus_sequencer #(.WIDTH(WIDTH), .FPU_LAT(FPU_LAT), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_long(req_long), .req_setflags(req_setflags),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_rd(req_rd), .req_rd_hi(req_rd_hi),
    .dpus_a(dpus_a), .dpus_b(dpus_b), .dpus_ctrl(dpus_ctrl),
    .dpus_result(dpus_result), .dpus_aux(dpus_aux), .dpus_flags(dpus_flags),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .flags_we(flags_we), .flags_out(flags_out), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] wa;
    logic [31:0] wd;
    logic       fwe;
    logic [3:0] flg;
    logic       done;
  } wr_t;

  wr_t         sb[$];
  wr_t         e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_cyc = 0;
  int          exp_acc = 0;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [3:0]  exp_ctrl = '0;
  logic [3:0]  last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] dut_rf[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes and checks handshake/operand behaviour every cycle
  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready", 64'(req_ready), 64'(cyc >= ready_cyc));
      if (cyc >= exp_acc) begin
        chk("dpus_a", 64'(dpus_a), 64'(exp_a));
        chk("dpus_b", 64'(dpus_b), 64'(exp_b));
        chk("dpus_ctrl", 64'(dpus_ctrl), 64'(exp_ctrl));
      end
      if (rf_we) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: wa=%0h wd=%0h expected no write (cycle %0d)", rf_wa, rf_wd, cyc);
        end else begin
          e = sb.pop_front();
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
          chk("rf_wa", 64'(rf_wa), 64'(e.wa));
          chk("rf_wd", 64'(rf_wd), 64'(e.wd));
          chk("flags_we", 64'(flags_we), 64'(e.fwe));
          chk("done", 64'(done), 64'(e.done));
          if (e.fwe) chk("flags_out", 64'(flags_out), 64'(e.flg));
        end
        last_wa = rf_wa;
        last_wd = rf_wd;
        dut_rf[rf_wa] = rf_wd;
      end else begin
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_flags_we", 64'(flags_we), 64'(0));
        chk("hold_rf_wa", 64'(rf_wa), 64'(last_wa));
        chk("hold_rf_wd", 64'(rf_wd), 64'(last_wd));
      end
    end
  end

  // Issue one op and record its expected writebacks from the latency rules
  task automatic issue(input logic [3:0] ctrl, input logic lng, input logic sf,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input logic [3:0] rdhi,
                       input logic [31:0] res, input logic [31:0] aux,
                       input logic [3:0] flg, input bit hold);
    int  n = 0;
    int  acc;
    int  lat;
    logic lg;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: req_ready=0 after %0d cycles expected 1", n);
      return;
    end
    req_ctrl = ctrl; req_long = lng; req_setflags = sf;
    req_srca = a; req_srcb = b; req_rd = rd; req_rd_hi = rdhi;
    dpus_result = res; dpus_aux = aux; dpus_flags = flg;
    req_valid = 1'b1;
    acc = cyc + 1;
    lg  = lng & ~ctrl[3];
    lat = ctrl[3] ? FPU_LAT + 1 : (lg ? 3 : 2);
    sb.push_back('{acc + lat - (lg ? 2 : 1), rd, res, sf, flg, !lg});
    if (lg) sb.push_back('{acc + 2, rdhi, aux, 1'b0, 4'h0, 1'b1});
    ready_cyc = acc + lat;
    exp_acc = acc; exp_a = a; exp_b = b; exp_ctrl = ctrl;
    @(negedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(req_ready && sb.size() == 0) && n < 100);
    req_valid = 1'b0;
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic rand_op(input bit hold);
    logic [3:0] rd;
    rd = 4'($urandom);
    issue(4'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, rd,
          ($urandom_range(0, 3) == 0) ? rd : 4'($urandom),
          $urandom, $urandom, 4'($urandom), hold);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_flags_we", 64'(flags_we), 64'(0));
    chk("rst_dpus_a", 64'(dpus_a), 64'(0));
    chk("rst_dpus_ctrl", 64'(dpus_ctrl), 64'(0));
    chk("rst_rf_wa", 64'(rf_wa), 64'(0));
    chk("rst_rf_wd", 64'(rf_wd), 64'(0));
    chk("rst_flags_out", 64'(flags_out), 64'(0));
    #1 reset = 1'b0;

    issue(OP_ADD, 1'b0, 1'b1, 32'd5, 32'd7, 4'd3, 4'd0, 32'd12, 32'd0, 4'b0100, 1'b0);
    issue(OP_UMULL, 1'b1, 1'b0, 32'd3, 32'd9, 4'd4, 4'd5, 32'h1, 32'hFFFF_FFFE, 4'b0010, 1'b0);
    issue(OP_FADD, 1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd6, 4'd9, 32'h4040_0000, 32'hDEAD_BEEF, 4'b0001, 1'b0);
    issue(OP_UMULL, 1'b1, 1'b1, 32'd1, 32'd2, 4'd7, 4'd7, 32'hA, 32'hB, 4'b1000, 1'b0);
    drain();
    chk("r7_final", 64'(dut_rf[7]), 64'(32'hB));

    for (int i = 0; i < 20; i++) rand_op(1'b1);
    drain();
    for (int i = 0; i < 20; i++) rand_op(1'b0);
    drain();

    issue(OP_SMULL, 1'b1, 1'b0, 32'h11, 32'h22, 4'd2, 4'd8, 32'h55, 32'h66, 4'b0011, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_rf_we", 64'(rf_we), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_dpus_ctrl", 64'(dpus_ctrl), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(1));
    sb.delete();
    ready_cyc = 0; exp_acc = 0; exp_a = '0; exp_b = '0; exp_ctrl = '0;
    last_wa = '0; last_wd = '0;
    @(negedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);

    issue(OP_FMUL, 1'b0, 1'b1, 32'h1, 32'h2, 4'd1, 4'd0, 32'h1234_5678, 32'h0, 4'b1010, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
